// File: rtl/serdes_channel_rx_hfcnt.sv
`default_nettype none
// serdes_channel_rx_hfcnt: hyperframe alignment, basic-frame/cycle counters and HFN/BFN extraction.
// Optional HFN sequence check built when SERDES_RX_HFN_CHECK_EN is defined.  Rev 1.0
module serdes_channel_rx_hfcnt #(
  parameter logic [7:0] C_BF_NUM_MAX = 8'd255,
  parameter logic [7:0] C_HFN_MAX    = 8'd149
) (
  input  logic        I_serdes_rx_clk,
  input  logic        I_serdes_rx_rst,
  input  logic        I_serdes_rx_ksync,
  input  logic [7:0]  I_serdes_rx_k_flag,
  input  logic [63:0] I_serdes_rx_data,
  input  logic [3:0]  I_serdes_rate,
  input  logic        I_8b10b_or_64b66b_sel,
  output logic        O_hf_start,
  output logic [7:0]  O_bf_num,
  output logic [6:0]  O_bf_cycle,
  output logic        O_frame_vld,
  output logic [7:0]  O_hfn,
  output logic [11:0] O_bfn,
  output logic        O_hf_info_vld,
  output logic        O_hf_err,
  output logic        O_hfn_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_K = 2'd1, RUN = 2'd2} state_t;
  state_t state;

  logic [7:0]  ctrl_byte;
  logic        kdet_in;
  logic [7:0]  s1_ctrl;
  logic [7:0]  s2_ctrl;
  logic        s1_kdet;
  logic [3:0]  s1_rate;
  logic [3:0]  rate_prev;
  logic [6:0]  n_cyc;
  logic [6:0]  last_cyc;
  logic        at_end;
  logic        rate_chg;
  logic        publish;
  logic [7:0]  hfn_shadow;
  logic [11:0] bfn_shadow;
  logic        unused_bits;

  assign unused_bits = ^{I_serdes_rx_data[55:8], I_serdes_rx_k_flag[6:1]};

  always_comb begin
    ctrl_byte = I_serdes_rx_data[7:0];
    kdet_in   = I_serdes_rx_k_flag[0] && (I_serdes_rx_data[7:0] == 8'hBC);
    if (I_8b10b_or_64b66b_sel) begin
      ctrl_byte = I_serdes_rx_data[63:56];
      kdet_in   = I_serdes_rx_k_flag[7] && (I_serdes_rx_data[63:56] == 8'hFD);
    end
  end

  always_ff @(posedge I_serdes_rx_clk or posedge I_serdes_rx_rst) begin
    if (I_serdes_rx_rst) begin
      s1_ctrl   <= 8'd0;
      s2_ctrl   <= 8'd0;
      s1_kdet   <= 1'b0;
      s1_rate   <= 4'd0;
      rate_prev <= 4'd0;
    end else begin
      s1_ctrl   <= ctrl_byte;
      s2_ctrl   <= s1_ctrl;
      s1_kdet   <= kdet_in;
      s1_rate   <= I_serdes_rate;
      rate_prev <= s1_rate;
    end
  end

  always_comb begin
    case (s1_rate)
      4'd0:    n_cyc = 7'd4;
      4'd1:    n_cyc = 7'd8;
      4'd2:    n_cyc = 7'd10;
      4'd3:    n_cyc = 7'd16;
      4'd4:    n_cyc = 7'd20;
      4'd5:    n_cyc = 7'd32;
      4'd6:    n_cyc = 7'd32;
      4'd7:    n_cyc = 7'd40;
      4'd8:    n_cyc = 7'd48;
      default: n_cyc = 7'd96;
    endcase
  end

  // Counters lag stage 1 by one cycle, so the last count coincides with the K in stage 1.
  assign last_cyc = n_cyc - 7'd1;
  assign at_end   = (O_bf_cycle == last_cyc) && (O_bf_num == C_BF_NUM_MAX);
  assign rate_chg = (s1_rate != rate_prev);
  assign publish  = (state == RUN) && I_serdes_rx_ksync && !rate_chg && at_end && s1_kdet;

  always_ff @(posedge I_serdes_rx_clk or posedge I_serdes_rx_rst) begin
    if (I_serdes_rx_rst) begin
      state         <= IDLE;
      O_hf_start    <= 1'b0;
      O_bf_num      <= 8'd0;
      O_bf_cycle    <= 7'd0;
      O_frame_vld   <= 1'b0;
      O_hfn         <= 8'd0;
      O_bfn         <= 12'd0;
      O_hf_info_vld <= 1'b0;
      O_hf_err      <= 1'b0;
    end else begin
      O_hf_start <= 1'b0;
      O_hf_err   <= 1'b0;
      if (!I_serdes_rx_ksync) begin
        state         <= IDLE;
        O_bf_num      <= 8'd0;
        O_bf_cycle    <= 7'd0;
        O_frame_vld   <= 1'b0;
        O_hf_info_vld <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_K;
          WAIT_K: begin
            if (s1_kdet) begin
              state       <= RUN;
              O_bf_num    <= 8'd0;
              O_bf_cycle  <= 7'd0;
              O_frame_vld <= 1'b1;
              O_hf_start  <= 1'b1;
            end
          end
          RUN: begin
            if (rate_chg) begin
              state         <= WAIT_K;
              O_bf_num      <= 8'd0;
              O_bf_cycle    <= 7'd0;
              O_frame_vld   <= 1'b0;
              O_hf_info_vld <= 1'b0;
            end else if (at_end) begin
              O_bf_num   <= 8'd0;
              O_bf_cycle <= 7'd0;
              if (publish) begin
                O_hf_start    <= 1'b1;
                O_hfn         <= hfn_shadow;
                O_bfn         <= bfn_shadow;
                O_hf_info_vld <= 1'b1;
              end else begin
                O_hf_err      <= 1'b1;
                state         <= WAIT_K;
                O_frame_vld   <= 1'b0;
                O_hf_info_vld <= 1'b0;
              end
            end else if (s1_kdet) begin
              // Misplaced K: flag it and realign on it in the same cycle.
              O_hf_err      <= 1'b1;
              O_hf_start    <= 1'b1;
              O_bf_num      <= 8'd0;
              O_bf_cycle    <= 7'd0;
              O_hf_info_vld <= 1'b0;
            end else if (O_bf_cycle == last_cyc) begin
              O_bf_cycle <= 7'd0;
              O_bf_num   <= O_bf_num + 8'd1;
            end else begin
              O_bf_cycle <= O_bf_cycle + 7'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // s2_ctrl is the control byte of the cycle the registered counters currently label.
  always_ff @(posedge I_serdes_rx_clk or posedge I_serdes_rx_rst) begin
    if (I_serdes_rx_rst) begin
      hfn_shadow <= 8'd0;
      bfn_shadow <= 12'd0;
    end else if ((state == RUN) && (O_bf_cycle == 7'd0)) begin
      case (O_bf_num)
        8'd64:   hfn_shadow        <= s2_ctrl;
        8'd128:  bfn_shadow[7:0]   <= s2_ctrl;
        8'd192:  bfn_shadow[11:8]  <= s2_ctrl[3:0];
        default: ;
      endcase
    end
  end

`ifdef SERDES_RX_HFN_CHECK_EN
  logic       hfn_seen;
  logic [7:0] hfn_expect;

  assign hfn_expect = (O_hfn == C_HFN_MAX) ? 8'd0 : (O_hfn + 8'd1);

  always_ff @(posedge I_serdes_rx_clk or posedge I_serdes_rx_rst) begin
    if (I_serdes_rx_rst) begin
      hfn_seen  <= 1'b0;
      O_hfn_err <= 1'b0;
    end else begin
      O_hfn_err <= publish && hfn_seen && (hfn_shadow != hfn_expect);
      if (publish) hfn_seen <= 1'b1;
    end
  end
`else
  assign O_hfn_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serdes_channel_rx_hfcnt.sv
`default_nettype none
// Randomized bench for serdes_channel_rx_hfcnt with an anchor-based hyperframe reference model.
module tb_serdes_channel_rx_hfcnt;

  localparam int MAXC = 80000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ksync = 1'b0;
  logic [7:0]  k_flag = 8'd0;
  logic [63:0] data = 64'd0;
  logic [3:0]  rate = 4'd0;
  logic        sel = 1'b0;

  logic        hf_start;
  logic [7:0]  bf_num;
  logic [6:0]  bf_cycle;
  logic        frame_vld;
  logic [7:0]  hfn;
  logic [11:0] bfn;
  logic        hf_info_vld;
  logic        hf_err;
  logic        hfn_err;

  always #5 clk = ~clk;

  serdes_channel_rx_hfcnt dut (
    .I_serdes_rx_clk       (clk),
    .I_serdes_rx_rst       (rst),
    .I_serdes_rx_ksync     (ksync),
    .I_serdes_rx_k_flag    (k_flag),
    .I_serdes_rx_data      (data),
    .I_serdes_rate         (rate),
    .I_8b10b_or_64b66b_sel (sel),
    .O_hf_start            (hf_start),
    .O_bf_num              (bf_num),
    .O_bf_cycle            (bf_cycle),
    .O_frame_vld           (frame_vld),
    .O_hfn                 (hfn),
    .O_bfn                 (bfn),
    .O_hf_info_vld         (hf_info_vld),
    .O_hf_err              (hf_err),
    .O_hfn_err             (hfn_err)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int         n_tab [10] = '{4, 8, 10, 16, 20, 32, 32, 40, 48, 96};
  logic [7:0] h_ctrl [MAXC];
  bit         h_kdet [MAXC];
  logic [3:0] h_rate [MAXC];
  bit         h_ks   [MAXC];
  logic [7:0] hfn_q [$];

  // Reference model state: alignment anchor is the input index of the K the counters count from.
  int          m_mode = 0;   // 0 idle, 1 hunting for K, 2 running
  int          anchor = 0;
  bit          m_info = 1'b0;
  logic [7:0]  m_hfn = 8'd0;
  logic [11:0] m_bfn = 12'd0;
  bit          m_seen = 1'b0;
  bit          e_start, e_err, e_hfn_err;
  int          e_num, e_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  endtask

  function automatic int n_of(input logic [3:0] r);
    if (r <= 4'd9) return n_tab[r];
    return 96;
  endfunction

  function automatic logic [7:0] ctrl_at(input int i);
    return (i < 0) ? 8'd0 : h_ctrl[i];
  endfunction

  function automatic bit kdet_at(input int i);
    return (i < 0) ? 1'b0 : h_kdet[i];
  endfunction

  function automatic logic [3:0] rate_at(input int i);
    return (i < 0) ? 4'd0 : h_rate[i];
  endfunction

  // Edge e sees raw ksync of input e and the stage-1 copy of input e-1.
  task automatic model_step(input int e);
    int j, n, pos;
    logic [7:0] new_hfn, b_lo, b_hi;
    j = e - 1;
    e_start = 1'b0; e_err = 1'b0; e_hfn_err = 1'b0;
    n = n_of(rate_at(j));
    if (!h_ks[e]) begin
      m_mode = 0; m_info = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (kdet_at(j)) begin anchor = j; m_mode = 2; e_start = 1'b1; end
    end else begin
      pos = j - anchor;
      if (rate_at(j) != rate_at(j - 1)) begin
        m_mode = 1; m_info = 1'b0;
      end else if (pos == 256 * n) begin
        if (kdet_at(j)) begin
          new_hfn = ctrl_at(anchor + 64 * n);
          b_lo    = ctrl_at(anchor + 128 * n);
          b_hi    = ctrl_at(anchor + 192 * n);
`ifdef SERDES_RX_HFN_CHECK_EN
          if (m_seen && (new_hfn != ((m_hfn == 8'd149) ? 8'd0 : m_hfn + 8'd1))) e_hfn_err = 1'b1;
`endif
          m_seen  = 1'b1;
          m_hfn   = new_hfn;
          m_bfn   = {b_hi[3:0], b_lo};
          m_info  = 1'b1;
          e_start = 1'b1;
          anchor  = j;
        end else begin
          e_err = 1'b1; m_mode = 1; m_info = 1'b0;
        end
      end else if (kdet_at(j)) begin
        e_err = 1'b1; e_start = 1'b1; anchor = j; m_info = 1'b0;
      end
    end
    if (m_mode == 2) begin
      pos   = j - anchor;
      e_num = (pos / n) % 256;
      e_cyc = pos % n;
    end else begin
      e_num = 0; e_cyc = 0;
    end
  endtask

  task automatic tick(input bit ks, input logic [3:0] r, input bit s, input bit is_k,
                      input bit has_ctrl, input logic [7:0] cbyte);
    logic [63:0] d;
    logic [7:0]  kf, cb, comma;
    if (cyc >= MAXC) begin
      chk("cycle_budget", 64'(cyc), 64'(MAXC - 1));
      finish_up();
    end
    d     = {$urandom, $urandom};
    kf    = 8'($urandom);
    comma = s ? 8'hFD : 8'hBC;
    cb    = s ? d[63:56] : d[7:0];
    if (has_ctrl) cb = cbyte;
    if (is_k) cb = comma;
    else if (cb == comma) cb = cb ^ 8'h01;
    if (s) begin d[63:56] = cb; if (is_k) kf[7] = 1'b1; end
    else   begin d[7:0]   = cb; if (is_k) kf[0] = 1'b1; end
    ksync = ks; rate = r; sel = s; data = d; k_flag = kf;
    h_ctrl[cyc] = cb; h_kdet[cyc] = is_k; h_rate[cyc] = r; h_ks[cyc] = ks;
    @(posedge clk);
    model_step(cyc);
    @(negedge clk);
    chk("hf_start",  64'(hf_start),    64'(e_start));
    chk("bf_num",    64'(bf_num),      64'(e_num));
    chk("bf_cycle",  64'(bf_cycle),    64'(e_cyc));
    chk("frame_vld", 64'(frame_vld),   64'(m_mode == 2));
    chk("hfn",       64'(hfn),         64'(m_hfn));
    chk("bfn",       64'(bfn),         64'(m_bfn));
    chk("info_vld",  64'(hf_info_vld), 64'(m_info));
    chk("hf_err",    64'(hf_err),      64'(e_err));
    chk("hfn_err",   64'(hfn_err),     64'(e_hfn_err));
    cyc++;
    if (fails >= 40) finish_up();
  endtask

  // One stimulus segment: K every 256*N cycles from first_k, optional early K, skipped K and ksync gap.
  task automatic seg(input logic [3:0] r, input bit s, input int ncyc, input int first_k,
                     input int inject_at, input int skip_nth, input int drop_at, input int drop_len,
                     input logic [11:0] bfn_val);
    int n, next_k, last_k, kn, rp;
    bit isk, hc, ks;
    logic [7:0] cb, rnd;
    n = n_of(r); next_k = first_k; last_k = -1000000; kn = 0;
    for (int t = 0; t < ncyc; t++) begin
      isk = 1'b0; hc = 1'b0; cb = 8'd0; rnd = 8'($urandom);
      ks = !((t >= drop_at) && (t < drop_at + drop_len));
      if (t == inject_at) begin
        isk = 1'b1; last_k = t; next_k = t + 256 * n;
      end else if (t == next_k) begin
        if (kn != skip_nth) isk = 1'b1;
        kn++; last_k = t; next_k = next_k + 256 * n;
      end
      rp = t - last_k;
      if (!isk && rp == 64 * n) begin
        hc = 1'b1; cb = (hfn_q.size() > 0) ? hfn_q.pop_front() : rnd;
      end else if (!isk && rp == 128 * n) begin
        hc = 1'b1; cb = bfn_val[7:0];
      end else if (!isk && rp == 192 * n) begin
        hc = 1'b1; cb = {rnd[7:4], bfn_val[11:8]};
      end
      tick(ks, r, s, isk, hc, cb);
    end
    hfn_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hf_start", 64'(hf_start), 64'd0);
    chk("rst_bf_num",   64'(bf_num),   64'd0);
    chk("rst_bf_cycle", 64'(bf_cycle), 64'd0);
    chk("rst_frame",    64'(frame_vld), 64'd0);
    chk("rst_hfn",      64'(hfn),      64'd0);
    chk("rst_bfn",      64'(bfn),      64'd0);
    chk("rst_info",     64'(hf_info_vld), 64'd0);
    chk("rst_errs",     64'({hf_err, hfn_err}), 64'd0);
    rst = 1'b0;

    // 8b10b rate 0, three hyperframes after a short ksync-low start
    seg(4'd0, 1'b0, 5 + 3 * 1024 + 8, 5, -1, -1, 0, 2, 12'h123);
    // 64b66b rate 9 with fixed HFN/BFN, published after the second hyperframe
    hfn_q = '{8'h05, 8'h05, 8'h05};
    seg(4'd9, 1'b1, 3 + 2 * 24576 + 6, 3, -1, -1, -1, 0, 12'hA3C);
    chk("r9_hfn",  64'(hfn), 64'h05);
    chk("r9_bfn",  64'(bfn), 64'hA3C);
    chk("r9_info", 64'(hf_info_vld), 64'd1);
    // rate 5, K injected 10 cycles early
    seg(4'd5, 1'b0, 3 + 8192 + 300, 3, 3 + 8192 - 10, -1, -1, 0, 12'h5A7);
    // rate 2, second K suppressed
    seg(4'd2, 1'b1, 3 + 2 * 2560 + 40, 3, -1, 1, -1, 0, 12'h0F1);
    // rate 0, one-cycle ksync drop mid-hyperframe
    seg(4'd0, 1'b0, 3 + 4 * 1024 + 10, 3, -1, -1, 3 + 1024 + 500, 1, 12'h777);
    // HFN sequence 148,149,0,2
    hfn_q = '{8'd148, 8'd149, 8'd0, 8'd2};
    seg(4'd0, 1'b1, 3 + 5 * 1024 + 10, 3, -1, -1, -1, 0, 12'h321);
    finish_up();
  end

endmodule
`default_nettype wire
